// File: rtl/l1_l2_arbiter.sv
// -----------------------------------------------------------------------------
// l1_l2_arbiter
//
// Shares the single L2 line port between the instruction cache (I$) and the
// data cache (D$). One line transaction (refill read or dirty-line writeback)
// is outstanding at a time: grant in IDLE, present to L2 in ISSUE, wait for
// the L2 line in WAIT, hand it back to the owning L1 in RESP.
//
// Handshake rule used on every channel: a transfer happens on a rising clock
// edge where both valid and ready are 1. A producer holds valid and all of its
// payload stable until that edge; ready may depend combinationally on valid.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   ic_req_*            I$ refill request (read only)
//   ic_resp_*           refill line valid / accept towards I$
//   dc_req_*            D$ request (we=1 writeback, we=0 refill)
//   dc_resp_*           refill line / writeback ack towards D$
//   resp_data_o         response line, shared by I$ and D$
//   l2_req_*            line request to L2 (line-aligned address)
//   l2_resp_*           line response from L2
//   dbg_state_o         current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
module l1_l2_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      ic_req_valid_i,
    output logic                      ic_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]     ic_req_addr_i,
    output logic                      ic_resp_valid_o,
    input  logic                      ic_resp_ready_i,

    input  logic                      dc_req_valid_i,
    input  logic                      dc_req_we_i,
    output logic                      dc_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]     dc_req_addr_i,
    input  logic [LINE_BYTES*8-1:0]   dc_req_wdata_i,
    output logic                      dc_resp_valid_o,
    input  logic                      dc_resp_ready_i,

    output logic [LINE_BYTES*8-1:0]   resp_data_o,

    output logic                      l2_req_valid_o,
    input  logic                      l2_req_ready_i,
    output logic                      l2_req_we_o,
    output logic [ADDR_WIDTH-1:0]     l2_req_addr_o,
    output logic [LINE_BYTES*8-1:0]   l2_req_wdata_o,
    input  logic                      l2_resp_valid_i,
    output logic                      l2_resp_ready_o,
    input  logic [LINE_BYTES*8-1:0]   l2_resp_data_i,

    output logic [1:0]                dbg_state_o
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);

    // Mask that clears the byte-offset bits of a line address.
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
        ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_W-1:0]     r_wdata;
    logic [LINE_W-1:0]     r_resp_data;

    logic                  w_dc_wb;
    logic                  w_grant_ic;
    logic                  w_grant_dc;
    logic                  w_resp_hs;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [ADDR_WIDTH-1:0] w_line_addr;

    assign w_dc_wb     = dc_req_valid_i && dc_req_we_i;
    assign w_req_addr  = w_grant_dc ? dc_req_addr_i : ic_req_addr_i;
    assign w_line_addr = w_req_addr & ~LOW_MASK;

    // Arbitration. Grants are gated by rst_i so that both ready outputs read 0
    // while reset is held, even though the state register already sits in IDLE.
    always_comb begin
        w_grant_ic = 1'b0;
        w_grant_dc = 1'b0;
        if (r_state == ST_IDLE && !rst_i) begin
            if (w_dc_wb) begin
                // A dirty line must leave D$ before it can refill, so a
                // writeback always goes first.
                w_grant_dc = 1'b1;
            end else if (ic_req_valid_i && dc_req_valid_i) begin
                if (r_last_grant == OWN_DC) begin
                    w_grant_ic = 1'b1;
                end else begin
                    w_grant_dc = 1'b1;
                end
            end else if (ic_req_valid_i) begin
                w_grant_ic = 1'b1;
            end else if (dc_req_valid_i) begin
                w_grant_dc = 1'b1;
            end
        end
    end

    // Response handshake with whichever L1 owns the transaction.
    assign w_resp_hs = (r_state == ST_RESP) &&
                       ((r_owner == OWN_IC) ? ic_resp_ready_i : dc_resp_ready_i);

    // Next state and outputs.
    always_comb begin
        w_state_nxt     = r_state;
        ic_req_ready_o  = w_grant_ic;
        dc_req_ready_o  = w_grant_dc;
        l2_req_valid_o  = 1'b0;
        l2_resp_ready_o = 1'b0;
        ic_resp_valid_o = 1'b0;
        dc_resp_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_ic || w_grant_dc) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                l2_req_valid_o = 1'b1;
                // A response presented together with the request accept is
                // left for WAIT; L2 keeps it valid until it is taken.
                if (l2_req_ready_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                l2_resp_ready_o = 1'b1;
                if (l2_resp_valid_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                ic_resp_valid_o = (r_owner == OWN_IC);
                dc_resp_valid_o = (r_owner == OWN_DC);
                if (w_resp_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign l2_req_we_o    = r_we;
    assign l2_req_addr_o  = r_addr;
    assign l2_req_wdata_o = r_wdata;
    assign resp_data_o    = r_resp_data;
    assign dbg_state_o    = r_state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant <= OWN_DC;
            r_owner      <= OWN_IC;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_data  <= '0;
        end else begin
            if (w_grant_ic || w_grant_dc) begin
                r_owner      <= w_grant_dc;
                r_last_grant <= w_grant_dc;
                r_we         <= w_grant_dc && dc_req_we_i;
                r_addr       <= w_line_addr;
                r_wdata      <= w_grant_dc ? dc_req_wdata_i : '0;
            end
            if (r_state == ST_WAIT && l2_resp_valid_i) begin
                r_resp_data <= l2_resp_data_i;
            end
        end
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
module tb_l1_l2_arbiter;
  localparam int AW = 32;
  localparam int LB = 64;
  localparam int LW = LB * 8;

  logic clk = 1'b0;
  logic rst;
  logic ic_req_valid_i, ic_req_ready_o, ic_resp_valid_o, ic_resp_ready_i;
  logic [AW-1:0] ic_req_addr_i;
  logic dc_req_valid_i, dc_req_we_i, dc_req_ready_o, dc_resp_valid_o, dc_resp_ready_i;
  logic [AW-1:0] dc_req_addr_i;
  logic [LW-1:0] dc_req_wdata_i;
  logic [LW-1:0] resp_data_o;
  logic l2_req_valid_o, l2_req_ready_i, l2_req_we_o, l2_resp_valid_i, l2_resp_ready_o;
  logic [AW-1:0] l2_req_addr_o;
  logic [LW-1:0] l2_req_wdata_o, l2_resp_data_i;
  logic [1:0] dbg_state_o;

  l1_l2_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
    .ic_req_addr_i(ic_req_addr_i), .ic_resp_valid_o(ic_resp_valid_o),
    .ic_resp_ready_i(ic_resp_ready_i),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_we_i(dc_req_we_i),
    .dc_req_ready_o(dc_req_ready_o), .dc_req_addr_i(dc_req_addr_i),
    .dc_req_wdata_i(dc_req_wdata_i), .dc_resp_valid_o(dc_resp_valid_o),
    .dc_resp_ready_i(dc_resp_ready_i),
    .resp_data_o(resp_data_o),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i),
    .l2_req_we_o(l2_req_we_o), .l2_req_addr_o(l2_req_addr_o),
    .l2_req_wdata_o(l2_req_wdata_o), .l2_resp_valid_i(l2_resp_valid_i),
    .l2_resp_ready_o(l2_resp_ready_o), .l2_resp_data_i(l2_resp_data_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed { logic we; logic [AW-1:0] addr; logic [LW-1:0] wdata; } l2_exp_t;
  typedef struct packed { logic chk; logic owner; logic [LW-1:0] data; } resp_exp_t;
  l2_exp_t   exp_l2_q[$];
  resp_exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected DUT event", name);
  endtask

  // ---------------- reference model ----------------
  // Pending L1 requests as the L1s see them, and the arbiter's fairness memory.
  bit            m_last_dc;
  bit            ic_pend, dc_pend, dc_we;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata;
  int            force_d1 = -1;

  // Contents returned by the L2 memory model for a line address.
  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (a == 32'h0000_1200) return {64{8'hA5}};
    return {16{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~32'h0000_003F;
  endfunction

  task automatic rand_line(output logic [LW-1:0] l);
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
  endtask

  task automatic drive_reqs();
    ic_req_valid_i = ic_pend;
    ic_req_addr_i  = ic_addr;
    dc_req_valid_i = dc_pend;
    dc_req_we_i    = dc_we;
    dc_req_addr_i  = dc_addr;
    dc_req_wdata_i = dc_wdata;
  endtask

  // Decide the winner from the arbitration rules and queue what L2 and the
  // winning L1 should see. w: 0 = I$, 1 = D$.
  task automatic model_grant(output bit w);
    l2_exp_t   le;
    resp_exp_t re;
    if (dc_pend && dc_we)       w = 1'b1;
    else if (ic_pend && dc_pend) w = !m_last_dc;
    else                         w = dc_pend;
    m_last_dc = w;
    le.we    = w ? dc_we : 1'b0;
    le.addr  = align(w ? dc_addr : ic_addr);
    le.wdata = w ? dc_wdata : '0;
    re.chk   = !le.we;
    re.owner = w;
    re.data  = line_of(le.addr);
    exp_l2_q.push_back(le);
    exp_q.push_back(re);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_grant(input bit w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ic_req_ready_o || dc_req_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("grant_wait");
    else check("grant_onehot", {dc_req_ready_o, ic_req_ready_o}, w ? 2'b10 : 2'b01);
  endtask

  // L2 responder: random accept delay, sometimes offers the response in the
  // same cycle it accepts the request.
  task automatic l2_serve();
    int d1;
    bit early;
    bit ok;
    logic [AW-1:0] a;
    d1 = (force_d1 >= 0) ? force_d1 : $urandom_range(0, 3);
    force_d1 = -1;
    early = ($urandom_range(0, 3) == 0);
    repeat (d1) begin @(posedge clk); #1; end
    a = l2_req_addr_o;
    l2_req_ready_i = 1'b1;
    if (early) begin l2_resp_valid_i = 1'b1; l2_resp_data_i = line_of(a); end
    @(posedge clk); #1;
    l2_req_ready_i = 1'b0;
    if (!early) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      l2_resp_valid_i = 1'b1;
      l2_resp_data_i  = line_of(a);
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (l2_resp_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("l2_resp_ready_wait");
    @(posedge clk); #1;
    l2_resp_valid_i = 1'b0;
  endtask

  task automatic wait_resp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((ic_resp_valid_o && ic_resp_ready_i) || (dc_resp_valid_o && dc_resp_ready_i)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("resp_wait");
  endtask

  task automatic do_txn(input bit gen_new);
    bit w;
    bit ok;
    @(posedge clk); #1;
    if (gen_new) begin
      if (!ic_pend && $urandom_range(0, 1) == 1) begin ic_pend = 1'b1; ic_addr = $urandom; end
      if (!dc_pend && $urandom_range(0, 1) == 1) begin
        dc_pend = 1'b1; dc_we = ($urandom_range(0, 1) == 1); dc_addr = $urandom; rand_line(dc_wdata);
      end
      if (!ic_pend && !dc_pend) begin ic_pend = 1'b1; ic_addr = $urandom; end
    end
    if (!ic_pend && !dc_pend) return;
    drive_reqs();
    model_grant(w);
    wait_grant(w, ok);
    if (!ok) return;
    @(posedge clk); #1;
    // The granted L1 drops its request and scribbles its fields; the
    // arbiter must be working from its own captured copy now.
    if (w) begin dc_pend = 1'b0; dc_addr = $urandom; rand_line(dc_wdata); end
    else begin ic_pend = 1'b0; ic_addr = $urandom; end
    drive_reqs();
    l2_serve();
    wait_resp();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ic_req_ready"}, ic_req_ready_o, 0);
    check({tag, "_dc_req_ready"}, dc_req_ready_o, 0);
    check({tag, "_ic_resp_valid"}, ic_resp_valid_o, 0);
    check({tag, "_dc_resp_valid"}, dc_resp_valid_o, 0);
    check({tag, "_resp_data"}, resp_data_o, 0);
    check({tag, "_l2_req_valid"}, l2_req_valid_o, 0);
    check({tag, "_l2_req_we"}, l2_req_we_o, 0);
    check({tag, "_l2_req_addr"}, l2_req_addr_o, 0);
    check({tag, "_l2_req_wdata"}, l2_req_wdata_o, 0);
    check({tag, "_l2_resp_ready"}, l2_resp_ready_o, 0);
  endtask

  task automatic reset_in_wait();
    bit w;
    bit ok;
    @(posedge clk); #1;
    ic_pend = 1'b1; ic_addr = 32'h0000_3000;
    drive_reqs();
    model_grant(w);
    wait_grant(w, ok);
    @(posedge clk); #1;
    ic_pend = 1'b0;
    drive_reqs();
    l2_req_ready_i = 1'b1;
    @(posedge clk); #1;
    l2_req_ready_i = 1'b0;
    @(negedge clk);
    check("wait_l2_resp_ready", l2_resp_ready_o, 1);
    #1;
    ic_req_valid_i = 1'b1; dc_req_valid_i = 1'b1; dc_req_we_i = 1'b1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_wait");
    exp_q.delete();
    exp_l2_q.delete();
    m_last_dc = 1'b1; ic_pend = 1'b0; dc_pend = 1'b0; dc_we = 1'b0;
    @(posedge clk); #1;
    drive_reqs();
    @(posedge clk); #1;
    rst = 1'b0;
    // A late L2 response for the abandoned transaction must go nowhere.
    l2_resp_valid_i = 1'b1;
    l2_resp_data_i  = line_of(32'h0000_3000);
    repeat (3) begin
      @(negedge clk);
      check("late_ic_resp_valid", ic_resp_valid_o, 0);
      check("late_dc_resp_valid", dc_resp_valid_o, 0);
      check("late_l2_resp_ready", l2_resp_ready_o, 0);
    end
    @(posedge clk); #1;
    l2_resp_valid_i = 1'b0;
  endtask

  // ---------------- L1 response-ready stimulus ----------------
  initial begin
    ic_resp_ready_i = 1'b0;
    dc_resp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      ic_resp_ready_i = ($urandom_range(0, 9) < 6);
      dc_resp_ready_i = ($urandom_range(0, 9) < 6);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit            txn_open;
  bit            p_l2v, p_l2r, p_l2we, p_icv, p_dcv, p_icr, p_dcr;
  logic [AW-1:0] p_addr;
  logic [LW-1:0] p_wdata, p_rdata;

  initial begin
    l2_exp_t   le;
    resp_exp_t re;
    forever begin
      @(negedge clk);
      if (rst) begin
        txn_open = 1'b0;
        p_l2v = 1'b0; p_icv = 1'b0; p_dcv = 1'b0;
      end else begin
        if (txn_open) check("busy_no_req_ready", {dc_req_ready_o, ic_req_ready_o}, 0);
        else if (ic_req_ready_o || dc_req_ready_o) txn_open = 1'b1;

        if (p_l2v && !p_l2r) begin
          check("l2_req_valid_held", l2_req_valid_o, 1);
          check("l2_req_addr_stable", l2_req_addr_o, p_addr);
          check("l2_req_wdata_stable", l2_req_wdata_o, p_wdata);
          check("l2_req_we_stable", l2_req_we_o, p_l2we);
        end
        if (l2_req_valid_o && l2_req_ready_i) begin
          if (exp_l2_q.size() == 0) begin
            fail_timeout("l2_req_unexpected");
          end else begin
            le = exp_l2_q.pop_front();
            check("l2_req_we", l2_req_we_o, le.we);
            check("l2_req_addr", l2_req_addr_o, le.addr);
            check("l2_req_wdata", l2_req_wdata_o, le.wdata);
          end
        end

        if (ic_resp_valid_o || dc_resp_valid_o)
          check("resp_valid_exclusive", {dc_resp_valid_o, ic_resp_valid_o} & {dc_resp_valid_o, ic_resp_valid_o} - 2'b01 & 2'b10 & {ic_resp_valid_o, 1'b0}, 0);
        if ((p_icv && !p_icr) || (p_dcv && !p_dcr)) begin
          check("resp_valid_held", {dc_resp_valid_o, ic_resp_valid_o}, {p_dcv, p_icv});
          check("resp_data_stable", resp_data_o, p_rdata);
        end
        if ((ic_resp_valid_o && ic_resp_ready_i) || (dc_resp_valid_o && dc_resp_ready_i)) begin
          if (exp_q.size() == 0) begin
            fail_timeout("resp_unexpected");
          end else begin
            re = exp_q.pop_front();
            check("resp_owner", {dc_resp_valid_o, ic_resp_valid_o}, re.owner ? 2'b10 : 2'b01);
            if (re.chk) check("resp_data", resp_data_o, re.data);
          end
          txn_open = 1'b0;
        end

        p_l2v = l2_req_valid_o; p_l2r = l2_req_ready_i; p_l2we = l2_req_we_o;
        p_addr = l2_req_addr_o; p_wdata = l2_req_wdata_o;
        p_icv = ic_resp_valid_o; p_dcv = dc_resp_valid_o;
        p_icr = ic_resp_ready_i; p_dcr = dc_resp_ready_i; p_rdata = resp_data_o;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h0000_1234;
    dc_req_valid_i = 1'b1; dc_req_we_i = 1'b1; dc_req_addr_i = 32'h8000_0040;
    dc_req_wdata_i = '1;
    l2_req_ready_i = 1'b0; l2_resp_valid_i = 1'b1; l2_resp_data_i = '1;
    ic_pend = 1'b0; dc_pend = 1'b0; dc_we = 1'b0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    m_last_dc = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("rst0");
    ic_req_valid_i = 1'b0; dc_req_valid_i = 1'b0; dc_req_we_i = 1'b0; l2_resp_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Both caches refill back-to-back: grants alternate starting with I$.
    for (int k = 0; k < 4; k++) begin
      if (!ic_pend) begin ic_pend = 1'b1; ic_addr = $urandom; end
      if (!dc_pend) begin dc_pend = 1'b1; dc_we = 1'b0; dc_addr = $urandom; rand_line(dc_wdata); end
      do_txn(1'b0);
    end
    repeat (2) do_txn(1'b0);

    // Single I$ refill of 0x1234 returning the 0xA5 line.
    ic_pend = 1'b1; ic_addr = 32'h0000_1234;
    do_txn(1'b0);

    // D$ writeback beats a simultaneous I$ refill; I$ follows.
    ic_pend = 1'b1; ic_addr = $urandom;
    dc_pend = 1'b1; dc_we = 1'b1; dc_addr = 32'h8000_0040; rand_line(dc_wdata);
    do_txn(1'b0);
    do_txn(1'b0);

    // L2 stalls the request for 5 cycles while another request waits.
    force_d1 = 5;
    ic_pend = 1'b1; ic_addr = $urandom;
    dc_pend = 1'b1; dc_we = 1'b0; dc_addr = $urandom; rand_line(dc_wdata);
    do_txn(1'b0);
    do_txn(1'b0);

    repeat (60) do_txn(1'b1);
    repeat (2) do_txn(1'b0);

    reset_in_wait();

    ic_pend = 1'b1; ic_addr = $urandom;
    dc_pend = 1'b1; dc_we = 1'b0; dc_addr = $urandom; rand_line(dc_wdata);
    do_txn(1'b0);
    do_txn(1'b0);
    repeat (6) do_txn(1'b1);
    repeat (2) do_txn(1'b0);
    repeat (3) @(negedge clk);

    if (exp_q.size() != 0 || exp_l2_q.size() != 0) fail_timeout("scoreboard_drain");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Shares the single L2 line port between the instruction cache and the data cache.
- Accepts one line request (refill read or dirty-line writeback) from either L1 and forwards it to L2.
- Captures the L2 line response and returns it to the requester that owns the transaction.
- Sits between the L1 caches and the L2 cache; exactly one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, physical address width.
- LINE_BYTES, 64, cache line size in bytes; line data width is LINE_BYTES*8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- ic_req_valid_i  in  1  I$ refill request valid (always a read).
- ic_req_ready_o  out  1  I$ request accepted this cycle.
- ic_req_addr_i  in  ADDR_WIDTH  I$ miss address.
- ic_resp_valid_o  out  1  refill line valid to I$.
- ic_resp_ready_i  in  1  I$ accepts the line.
- dc_req_valid_i  in  1  D$ request valid.
- dc_req_we_i  in  1  1 = writeback, 0 = refill.
- dc_req_ready_o  out  1  D$ request accepted this cycle.
- dc_req_addr_i  in  ADDR_WIDTH  D$ line address.
- dc_req_wdata_i  in  LINE_BYTES*8  writeback line.
- dc_resp_valid_o  out  1  refill line or writeback ack valid to D$.
- dc_resp_ready_i  in  1  D$ accepts the response.
- resp_data_o  out  LINE_BYTES*8  response line, shared by I$ and D$.
- l2_req_valid_o  out  1  request to L2.
- l2_req_ready_i  in  1  L2 accepts the request.
- l2_req_we_o  out  1  write request.
- l2_req_addr_o  out  ADDR_WIDTH  line-aligned address.
- l2_req_wdata_o  out  LINE_BYTES*8  writeback data.
- l2_resp_valid_i  in  1  L2 response valid.
- l2_resp_ready_o  out  1  arbiter accepts the response.
- l2_resp_data_i  in  LINE_BYTES*8  response line.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, last_grant=DC, captured request registers cleared. All valid/ready outputs 0, all data/address outputs 0. Reset mid-transaction abandons it; no response is delivered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration, in priority order:
  1. A D$ writeback (dc_req_valid_i && dc_req_we_i) always wins.
  2. Otherwise, if both caches request, grant round-robin against last_grant.
  3. Otherwise, a single requester wins.
- IDLE grant actions:
  - The granted *_req_ready_o is 1 combinationally in the same cycle; the other stays 0.
  - Capture owner, we, addr with the low $clog2(LINE_BYTES) bits forced to 0, and wdata (D$ only; zero for I$).
  - Update last_grant and go to ISSUE.
- ISSUE: l2_req_valid_o=1 with the captured fields held stable. When l2_req_ready_i=1, go to WAIT.
- WAIT:
  - l2_resp_ready_o=1.
  - On l2_resp_valid_i, capture l2_resp_data_i into the response register and go to RESP.
  - For a writeback, the response is an ack; its data is still captured but is don't-care.
  - l2_resp_valid_i is ignored in every other state.
- RESP:
  - The owner's *_resp_valid_o=1 and resp_data_o=response register; the non-owner's resp_valid stays 0.
  - Hold until the owner's resp_ready_i=1, then go to IDLE.
- Latency:
  - Grant cycle to l2_req_valid_o: 1 cycle.
  - L2 response capture to resp_valid: 1 cycle.
  - Minimum round trip when L2 is ready and responds immediately: 4 cycles, request to response handshake.
- No new request is accepted until the RESP handshake completes; both *_req_ready_o are 0 outside IDLE.
- A requester that drops valid before being granted is simply not granted.
- Requests arriving while busy wait; their valid and fields must be held by the L1.
- If l2_req_ready_i and l2_resp_valid_i are both asserted in the same ISSUE cycle, the response is not taken: the arbiter moves to WAIT and takes it there. L2 must hold resp valid until resp ready.

Test Plan:
- Only I$ requests addr 0x0000_1234 -> ic_req_ready_o=1 same cycle; l2_req_addr_o=0x0000_1200, we=0. L2 returns line 0xA5 repeated -> ic_resp_valid_o=1, resp_data_o=0xA5 pattern, dc_resp_valid_o=0.
- I$ and D$ refills asserted together for 4 back-to-back transactions, starting from reset -> grants alternate I$, D$, I$, D$.
- D$ writeback of addr 0x8000_0040 plus I$ refill in the same cycle -> D$ granted; l2_req_we_o=1, l2_req_wdata_o equals dc_req_wdata_i. I$ is served next.
- l2_req_ready_i held low for 5 cycles -> l2_req_valid_o stays 1 with address and data stable; no *_req_ready_o pulses.
- ic_resp_ready_i held low for 3 cycles in RESP -> ic_resp_valid_o and resp_data_o held stable; a new dc request is not accepted until the handshake.
- rst_i asserted while in WAIT -> all outputs 0 immediately. A later l2_resp_valid_i produces no resp_valid, and the next request proceeds normally.
